// File: rtl/mcuspi_rx.sv
// SPI (mode 0, MSB first) receiver for MCU commands, fully synchronous to clk_sys.
// Pins are oversampled; bytes are strobed out with their index within the chip-select frame.
module mcuspi_rx #(
    parameter int FRAME_BYTES = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       mcu_csn,
    input  logic       mcu_sck,
    input  logic       mcu_mosi,
    output logic [7:0] spi_data,
    output logic       spi_vld,
    output logic [4:0] spi_idx,
    output logic       spi_sof,
    output logic       spi_eof,
    output logic       spi_err,
    output logic       spi_ovf
);

    localparam int BCW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES:0] csn_q, sck_q, mosi_q, fill;
    logic [2:0]           bit_cnt;
    logic [BCW-1:0]       byte_cnt;
    logic [7:0]           shifter;
    logic                 eof_pend;

    logic csn_cur, csn_prv, sck_cur, sck_prv, mosi_s, sync_ok;
    logic csn_fall, csn_rise, sck_rise, bit_take, byte_done;
    logic start, emit_vld, set_ovf, end_frame;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            csn_q  <= '1;
            sck_q  <= '0;
            mosi_q <= '0;
            fill   <= '0;
        end else begin
            csn_q  <= {csn_q[SYNC_STAGES-1:0], mcu_csn};
            sck_q  <= {sck_q[SYNC_STAGES-1:0], mcu_sck};
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], mcu_mosi};
            fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chains hold real pin samples, so a csn
    // held low across reset cannot fake a falling edge.
    assign sync_ok  = fill[SYNC_STAGES];
    assign csn_cur  = csn_q[SYNC_STAGES-1];
    assign csn_prv  = csn_q[SYNC_STAGES];
    assign sck_cur  = sck_q[SYNC_STAGES-1];
    assign sck_prv  = sck_q[SYNC_STAGES];
    assign mosi_s   = mosi_q[SYNC_STAGES];

    assign csn_fall = sync_ok &  csn_prv & ~csn_cur;
    assign csn_rise = sync_ok & ~csn_prv &  csn_cur;
    assign sck_rise = sync_ok & ~sck_prv &  sck_cur;

    // A bit coinciding with the csn rising edge still counts (csn was low a cycle ago).
    assign bit_take  = (state != IDLE) & sck_rise & (~csn_cur | csn_rise);
    assign byte_done = bit_take & (bit_cnt == 3'd7);

    always_ff @(posedge clk_sys) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        emit_vld  = 1'b0;
        set_ovf   = 1'b0;
        end_frame = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = RECV;
                    start     = 1'b1;
                end
            end
            RECV: begin
                if (byte_done) begin
                    emit_vld = 1'b1;
                    if (byte_cnt == BCW'(FRAME_BYTES - 1)) state_nxt = DROP;
                end
                if (csn_rise) begin
                    state_nxt = IDLE;
                    end_frame = 1'b1;
                end
            end
            DROP: begin
                set_ovf = byte_done;
                if (csn_rise) begin
                    state_nxt = IDLE;
                    end_frame = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shifter  <= '0;
            eof_pend <= 1'b0;
            spi_data <= '0;
            spi_vld  <= 1'b0;
            spi_idx  <= '0;
            spi_sof  <= 1'b0;
            spi_eof  <= 1'b0;
            spi_err  <= 1'b0;
            spi_ovf  <= 1'b0;
        end else begin
            spi_vld <= emit_vld;
            spi_sof <= emit_vld & (byte_cnt == '0);
            if (start) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                shifter  <= '0;
            end else if (bit_take) begin
                bit_cnt <= bit_cnt + 3'd1;
                shifter <= {shifter[6:0], mosi_s};
            end
            if (emit_vld) begin
                spi_data <= {shifter[6:0], mosi_s};
                spi_idx  <= 5'(byte_cnt);
                byte_cnt <= byte_cnt + BCW'(1);
            end
            if (start)        spi_ovf <= 1'b0;
            else if (set_ovf) spi_ovf <= 1'b1;
            // A frame ending on its last bit reports eof one cycle after the byte strobe.
            eof_pend <= end_frame & byte_done;
            spi_eof  <= (end_frame & ~byte_done) | eof_pend;
            spi_err  <= end_frame & ~byte_done & (bit_cnt != 3'd0);
        end
    end

endmodule

// File: doc/mcuspi_rx.md
MCUSPI_RX -- requirements
Module: mcuspi_rx

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 32, giving the maximum bytes accepted per chip-select frame (32 bytes = 256 bits).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of metastability flops on each MCU pin input.
REQ-003 The block SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mcu_csn, input, 1 bit: SPI chip select, active-low, asynchronous to clk_sys.
REQ-006 The block SHALL have port mcu_sck, input, 1 bit: SPI clock, mode 0, asynchronous to clk_sys.
REQ-007 The block SHALL have port mcu_mosi, input, 1 bit: SPI data, MSB first, asynchronous to clk_sys.
REQ-008 The block SHALL have port spi_data, output, 8 bits: last completed byte.
REQ-009 The block SHALL have port spi_vld, output, 1 bit: one-cycle strobe qualifying spi_data.
REQ-010 The block SHALL have port spi_idx, output, 5 bits: byte index of spi_data within the current frame.
REQ-011 The block SHALL have port spi_sof, output, 1 bit: asserted with spi_vld for byte 0 of a frame.
REQ-012 The block SHALL have port spi_eof, output, 1 bit: one-cycle pulse when a frame ends (csn deasserts).
REQ-013 The block SHALL have port spi_err, output, 1 bit: one-cycle pulse, issued with spi_eof, when the frame ends on a partial byte.
REQ-014 The block SHALL have port spi_ovf, output, 1 bit: sticky flag set when more than FRAME_BYTES bytes arrive in a frame.

Function
REQ-015 Each of csn, sck and mosi SHALL pass through SYNC_STAGES flops plus one history flop; edges are detected from the last two stages.
REQ-016 A bit SHALL be sampled from synchronized mosi on a detected sck rising edge while synchronized csn is low; sck falling edges SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, RECV and DROP; reset enters IDLE.
REQ-018 IDLE -> RECV on a detected csn falling edge; the bit counter (3 bits) and byte counter SHALL be cleared, and spi_ovf SHALL be cleared.
REQ-019 In RECV, the shifter SHALL shift left, inserting the new bit at bit 0; on the 8th bit, spi_data SHALL load the shifter value plus the new bit, and spi_vld SHALL pulse on the next cycle.
REQ-020 spi_vld latency SHALL be exactly 1 clk_sys cycle after the cycle in which the 8th sck rising edge is detected.
REQ-021 spi_idx SHALL equal the byte count before increment; spi_sof = spi_vld AND (spi_idx==0).
REQ-022 When the byte count reaches FRAME_BYTES, the FSM SHALL go RECV -> DROP; in DROP, further completed bytes SHALL produce no spi_vld and SHALL set spi_ovf.
REQ-023 A detected csn rising edge in RECV or DROP SHALL go to IDLE and pulse spi_eof on the next cycle; spi_err SHALL pulse with it if the bit counter is nonzero.
REQ-024 If a csn rising edge and an 8th sck rising edge are detected in the same cycle, the byte SHALL complete (spi_vld) and spi_eof SHALL follow one cycle after spi_vld, with spi_err low.
REQ-025 An sck edge while csn is synchronized-high, or a csn falling edge while in RECV/DROP, SHALL be ignored.
REQ-026 mcu_sck high and low times are each at least SYNC_STAGES+2 clk_sys cycles; the block is not required to capture faster clocks.
REQ-027 spi_data SHALL hold its value between strobes.

Reset
REQ-028 With rst high at a clk_sys edge, the following SHALL be cleared: state=IDLE, spi_data=0, spi_vld=0, spi_idx=0, spi_sof=0, spi_eof=0, spi_err=0, spi_ovf=0, all counters and shifter cleared, and sync flops set to idle levels (csn=1, sck=0, mosi=0).
REQ-029 Reset asserted mid-frame SHALL discard the partial byte with no spi_eof; after release, a still-low csn SHALL NOT start a frame until a new csn falling edge.

Verification
REQ-030 Test: csn low, send bytes 0xA5, 0x3C, then csn high -> two spi_vld strobes: data 0xA5 idx 0 sof 1, then data 0x3C idx 1 sof 0; spi_eof one pulse; spi_err 0.
REQ-031 Test: send 33 bytes 0x00..0x20 in one frame -> 32 strobes with idx 0..31; byte 0x20 produces no strobe; spi_ovf=1 until the next csn falling edge.
REQ-032 Test: send 0xFF then 5 bits, then csn high -> one strobe with 0xFF; spi_eof and spi_err pulse in the same cycle.
REQ-033 Test: assert rst for 1 cycle after 4 bits, keep csn low and send 8 bits -> no strobe; then csn high/low and send 0x81 -> strobe 0x81 idx 0.
REQ-034 Test: a cycle-level check of the 8th sck rising edge detected at cycle N -> spi_vld high at cycle N+1 only.
REQ-035 Test: toggle sck with csn high -> no spi_vld and no state change.
